// File: rtl/sram_axi_bridge.sv
// Instruction/data sram-like ports to one AXI3 master: per-channel outstanding reads plus a posted write buffer.
// Optional sticky response-error flag enabled by defining SRAM_AXI_BUS_ERR_EN.
module sram_axi_bridge #(
    parameter int RD_DEPTH = 2,
    parameter int WB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_p,
    // instruction read port
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_read_ok,
    output logic [31:0] data_rdata,
    output logic        data_write_full,
    output logic        bus_err,
    // AXI3 read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI3 read data
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI3 write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    // AXI3 write data
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI3 write response
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam int CW = $clog2(RD_DEPTH + 1);
    localparam int PW = $clog2(WB_DEPTH);
    localparam logic [CW-1:0] RD_MAX  = CW'(RD_DEPTH);
    localparam logic [PW:0]   WB_FULL = (PW + 1)'(WB_DEPTH);

    logic [CW-1:0] inst_cnt, data_cnt;
    logic          slot_free, data_rd_grant, raw_hit;
    logic          inst_rsp, data_rsp;

    // Pointers carry one wrap bit so "all entries pending" differs from "empty".
    logic [PW:0]   wb_head, wb_tail, wb_aw_ptr, wb_w_ptr, wb_count;
    logic [31:0]   wb_addr [WB_DEPTH];
    logic [31:0]   wb_data [WB_DEPTH];
    logic [3:0]    wb_strb [WB_DEPTH];
    logic          wb_push, wb_pop;
    logic [PW-1:0] raw_offs;

    assign arlen   = 8'd0;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = 4'd1;
    assign awlen   = 8'd0;
    assign awsize  = 3'd2;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = 4'd1;
    assign wlast   = 1'b1;
    assign rready  = 1'b1;
    assign bready  = 1'b1;

    assign slot_free     = !arvalid || arready;
    assign data_rd_grant = data_req && !data_wr && slot_free && (data_cnt < RD_MAX) && !raw_hit;
    assign data_addr_ok  = data_rd_grant;
    assign inst_addr_ok  = inst_req && slot_free && (inst_cnt < RD_MAX) && !data_rd_grant;

    always_ff @(posedge clk) begin
        if (rst_p) begin
            arvalid <= 1'b0;
        end else if (data_rd_grant || inst_addr_ok) begin
            arvalid <= 1'b1;
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (data_rd_grant) begin
            araddr <= data_addr;
            arid   <= 4'd1;
        end else if (inst_addr_ok) begin
            araddr <= inst_addr;
            arid   <= 4'd0;
        end
    end

    assign inst_rsp     = rvalid && (rid == 4'd0);
    assign data_rsp     = rvalid && (rid == 4'd1);
    assign inst_data_ok = inst_rsp;
    assign data_read_ok = data_rsp;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    always_ff @(posedge clk) begin
        if (rst_p) begin
            inst_cnt <= '0;
            data_cnt <= '0;
        end else begin
            inst_cnt <= inst_cnt + CW'(inst_addr_ok) - CW'(inst_rsp);
            data_cnt <= data_cnt + CW'(data_rd_grant) - CW'(data_rsp);
        end
    end

    assign wb_count        = wb_tail - wb_head;
    assign data_write_full = (wb_count == WB_FULL);
    assign wb_push         = data_req && data_wr && !data_write_full;
    assign wb_pop          = bvalid;

    assign awvalid = (wb_aw_ptr != wb_tail);
    assign awaddr  = wb_addr[wb_aw_ptr[PW-1:0]];
    assign wvalid  = (wb_w_ptr != wb_tail);
    assign wdata   = wb_data[wb_w_ptr[PW-1:0]];
    assign wstrb   = wb_strb[wb_w_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst_p) begin
            wb_head   <= '0;
            wb_tail   <= '0;
            wb_aw_ptr <= '0;
            wb_w_ptr  <= '0;
        end else begin
            if (wb_push)            wb_tail   <= wb_tail + 1'b1;
            if (wb_pop)             wb_head   <= wb_head + 1'b1;
            if (awvalid && awready) wb_aw_ptr <= wb_aw_ptr + 1'b1;
            if (wvalid && wready)   wb_w_ptr  <= wb_w_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_push) begin
            wb_addr[wb_tail[PW-1:0]] <= data_addr;
            wb_data[wb_tail[PW-1:0]] <= data_wdata;
            wb_strb[wb_tail[PW-1:0]] <= data_wstrb;
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        raw_hit  = 1'b0;
        raw_offs = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            raw_offs = PW'(i) - wb_head[PW-1:0];
            if (({1'b0, raw_offs} < wb_count) && (wb_addr[i][31:2] == data_addr[31:2])) begin
                raw_hit = 1'b1;
            end
        end
    end

`ifdef SRAM_AXI_BUS_ERR_EN
    always_ff @(posedge clk) begin
        if (rst_p) begin
            bus_err <= 1'b0;
        end else if ((rvalid && (rresp != 2'b00)) || (bvalid && (bresp != 2'b00))) begin
            bus_err <= 1'b1;
        end
    end

    logic unused_inputs;
    assign unused_inputs = &{1'b0, rlast, bid};
`else
    assign bus_err = 1'b0;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, rlast, bid, rresp, bresp};
`endif

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench itself plays the AXI slave cycle by cycle.
module tb_sram_axi_bridge;

    logic        clk;
    logic        rst_p;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_read_ok;
    logic [31:0] data_rdata;
    logic        data_write_full, bus_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef SRAM_AXI_BUS_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    sram_axi_bridge #(.RD_DEPTH(2), .WB_DEPTH(4)) dut (
        .clk(clk), .rst_p(rst_p),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_read_ok(data_read_ok), .data_rdata(data_rdata),
        .data_write_full(data_write_full), .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_p = 1'b1;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wstrb = '0; data_wdata = '0;
        arready = 1'b1; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = '0; bvalid = 1'b0;
        step(); step();
        #1;
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_awvalid", awvalid, 0);
        check_eq("rst_wvalid", wvalid, 0);
        check_eq("rst_bus_err", bus_err, 0);
        check_eq("rst_full", data_write_full, 0);
        check_eq("rst_inst_ok", inst_addr_ok, 0);
        check_eq("rst_data_ok", data_addr_ok, 0);
        check_eq("rst_arlen", arlen, 0);
        check_eq("rst_arsize", arsize, 2);
        check_eq("rst_wlast", wlast, 1);
        rst_p = 1'b0;
        step();

        // inst streaming with two outstanding
        inst_req = 1'b1; inst_addr = 32'h0; #1;
        check_eq("is_ok0", inst_addr_ok, 1);
        step();
        inst_addr = 32'h4; #1;
        check_eq("is_ok1", inst_addr_ok, 1);
        check_eq("is_arvalid0", arvalid, 1);
        check_eq("is_araddr0", araddr, 32'h0);
        check_eq("is_arid0", arid, 0);
        step();
        inst_addr = 32'h8; #1;
        check_eq("is_ok2_blocked", inst_addr_ok, 0);
        check_eq("is_araddr1", araddr, 32'h4);
        step();
        #1;
        check_eq("is_arvalid_drop", arvalid, 0);
        check_eq("is_still_blocked", inst_addr_ok, 0);
        step();
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hA0; #1;
        check_eq("is_r0_ok", inst_data_ok, 1);
        check_eq("is_r0_data", inst_rdata, 32'hA0);
        check_eq("is_r0_not_data", data_read_ok, 0);
        step();
        rdata = 32'hA4; #1;
        check_eq("is_ok2_after_r", inst_addr_ok, 1);
        check_eq("is_r1_ok", inst_data_ok, 1);
        check_eq("is_r1_data", inst_rdata, 32'hA4);
        step();
        inst_req = 1'b0; rvalid = 1'b0; #1;
        check_eq("is_arvalid2", arvalid, 1);
        check_eq("is_araddr2", araddr, 32'h8);
        step();
        rvalid = 1'b1; rdata = 32'hA8; #1;
        check_eq("is_r2_data", inst_rdata, 32'hA8);
        step();
        rvalid = 1'b0;

        // data read wins over inst
        inst_req = 1'b1; inst_addr = 32'h40;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h100; #1;
        check_eq("arb_data_ok", data_addr_ok, 1);
        check_eq("arb_inst_ok", inst_addr_ok, 0);
        step();
        data_req = 1'b0; #1;
        check_eq("arb_arid_data", arid, 1);
        check_eq("arb_araddr_data", araddr, 32'h100);
        check_eq("arb_inst_next", inst_addr_ok, 1);
        step();
        inst_req = 1'b0; #1;
        check_eq("arb_arid_inst", arid, 0);
        check_eq("arb_araddr_inst", araddr, 32'h40);
        step();
        rvalid = 1'b1; rid = 4'd1; rdata = 32'h111; #1;
        check_eq("arb_data_rok", data_read_ok, 1);
        check_eq("arb_data_rdata", data_rdata, 32'h111);
        check_eq("arb_no_inst_rok", inst_data_ok, 0);
        step();
        rid = 4'd0; rdata = 32'h222; #1;
        check_eq("arb_inst_rok", inst_data_ok, 1);
        check_eq("arb_no_data_rok", data_read_ok, 0);
        step();
        rvalid = 1'b0;

        // write buffer fills with AW/W stalled
        awready = 1'b0; wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
            data_addr = 32'h300 + 32'(4 * i); data_wdata = 32'hC0DE0000 + 32'(i); #1;
            check_eq("wb_not_full", data_write_full, 0);
            check_eq("wb_write_no_addr_ok", data_addr_ok, 0);
            step();
        end
        data_addr = 32'h310; data_wdata = 32'h00000BAD; #1;
        check_eq("wb_full", data_write_full, 1);
        check_eq("wb_awvalid", awvalid, 1);
        check_eq("wb_awaddr0", awaddr, 32'h300);
        check_eq("wb_wdata0", wdata, 32'hC0DE0000);
        check_eq("wb_wstrb0", wstrb, 32'hF);
        step();
        data_req = 1'b0; awready = 1'b1; wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("wb_awaddr_seq", awaddr, 32'h300 + 32'(4 * i));
            check_eq("wb_wdata_seq", wdata, 32'hC0DE0000 + 32'(i));
            step();
        end
        awready = 1'b0; wready = 1'b0; #1;
        check_eq("wb_fifth_not_taken", awvalid, 0);
        check_eq("wb_w_drained", wvalid, 0);
        check_eq("wb_full_until_b", data_write_full, 1);
        bvalid = 1'b1; #1;
        check_eq("wb_full_in_b_cycle", data_write_full, 1);
        step();
        bvalid = 1'b0; #1;
        check_eq("wb_full_drop", data_write_full, 0);
        bvalid = 1'b1;
        repeat (3) step();
        bvalid = 1'b0; #1;
        check_eq("wb_drained_awvalid", awvalid, 0);

        // read-after-write stall
        awready = 1'b1; wready = 1'b1;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h200;
        data_wdata = 32'hDEADBEEF; data_wstrb = 4'hF; #1;
        step();
        data_wr = 1'b0; data_addr = 32'h203; #1;
        check_eq("raw_stall0", data_addr_ok, 0);
        check_eq("raw_awaddr", awaddr, 32'h200);
        check_eq("raw_wdata", wdata, 32'hDEADBEEF);
        step();
        data_addr = 32'h204; #1;
        check_eq("raw_other_word", data_addr_ok, 1);
        step();
        data_addr = 32'h203; #1;
        check_eq("raw_stall1", data_addr_ok, 0);
        check_eq("raw_ar_id", arid, 1);
        check_eq("raw_ar_addr", araddr, 32'h204);
        step();
        #1;
        check_eq("raw_stall2", data_addr_ok, 0);
        step();
        bvalid = 1'b1; #1;
        step();
        bvalid = 1'b0; #1;
        check_eq("raw_release", data_addr_ok, 1);
        data_req = 1'b0; #1;
        step();
        rvalid = 1'b1; rid = 4'd1; rdata = 32'h00204204; #1;
        check_eq("raw_rd204_ok", data_read_ok, 1);
        check_eq("raw_rd204_data", data_rdata, 32'h00204204);
        step();
        rvalid = 1'b0;

        // W completes before AW; entry held until B
        awready = 1'b0; wready = 1'b1;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h400; data_wdata = 32'h55AA55AA; #1;
        step();
        data_req = 1'b0; #1;
        check_eq("wfa_wvalid", wvalid, 1);
        check_eq("wfa_awvalid", awvalid, 1);
        check_eq("wfa_wdata", wdata, 32'h55AA55AA);
        step();
        #1;
        check_eq("wfa_w_done", wvalid, 0);
        check_eq("wfa_aw_pending", awvalid, 1);
        step(); step();
        awready = 1'b1; #1;
        check_eq("wfa_awaddr", awaddr, 32'h400);
        step();
        awready = 1'b0; #1;
        check_eq("wfa_aw_done", awvalid, 0);
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h400; #1;
        check_eq("wfa_held_until_b", data_addr_ok, 0);
        data_req = 1'b0; bvalid = 1'b1; #1;
        step();
        bvalid = 1'b0; data_req = 1'b1; #1;
        check_eq("wfa_popped", data_addr_ok, 1);
        data_req = 1'b0; #1;
        step();

        // response error flag
        inst_req = 1'b1; inst_addr = 32'h500; #1;
        step();
        inst_addr = 32'h504; #1;
        step();
        inst_req = 1'b0; #1;
        step();
        rvalid = 1'b1; rid = 4'd0; rresp = 2'b10; rdata = 32'h5; #1;
        check_eq("err_before", bus_err, 0);
        step();
        rresp = 2'b00; #1;
        check_eq("err_set", bus_err, ERR_EXP);
        step();
        rvalid = 1'b0; #1;
        check_eq("err_held", bus_err, ERR_EXP);
        rst_p = 1'b1;
        step();
        rst_p = 1'b0; #1;
        check_eq("err_cleared", bus_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
